arith_bus_master: RTL and testbench
===================================

// Module: arith_bus_master
// PURPOSE
//  Bus initiator for the memory-mapped divide peripheral (8-bit 6502-style cs/rwb/addr bus).
//  Accepts a 16-bit numer/denom request via valid/ready, writes regs 0-3, waits the unit
//  latency, reads regs 4-7, and returns quotient/remainder via valid/ready. Lets fabric
//  logic use the divider without CPU involvement; sits beside the CPU on the same bus mux.
// PARAMETERS
//  OPER_W        16  operand/result width; fixed at 2 bus bytes
//  LATENCY       18  idle cycles between the last write access and the first read access; 0 allowed
//  ACCESS_CYCLES 2   clk cycles each bus access is held; >=2 (responder writes on negedge)
// PORTS
//  clk          in   1   system clock; all state on posedge
//  reset        in   1   reset, synchronous, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE
//  req_numer    in   16  numerator, sampled on req handshake
//  req_denom    in   16  denominator, sampled on req handshake
//  rsp_valid    out  1   result present; held until rsp_ready
//  rsp_ready    in   1   consumer accepts result
//  rsp_quotient out  16  quotient, stable while rsp_valid
//  rsp_remain   out  16  remainder, stable while rsp_valid
//  busy         out  1   high in any state other than IDLE
//  bus_cs       out  1   chip select to peripheral
//  bus_rwb      out  1   1=read, 0=write
//  bus_addr     out  3   register index 0-7
//  bus_wdata    out  8   write data
//  bus_rdata    in   8   read data from peripheral (combinational from bus_addr)
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, busy=0, bus_cs=0, bus_rwb=1, bus_addr=0,
//   bus_wdata=0, rsp_quotient=rsp_remain=0, all counters 0. Bus outputs are registered.
//  IDLE: req_valid&req_ready latches operands -> WRITE, beat=0. No other exit.
//  WRITE: beat b=0..3 drives cs=1,rwb=0,addr=b, wdata = numer[7:0],numer[15:8],
//   denom[7:0],denom[15:8]; each beat held exactly ACCESS_CYCLES cycles, beats back-to-back.
//   After beat 3: -> WAIT if LATENCY>0, else -> READ. cs=0,rwb=1 outside accesses.
//  WAIT: cs=0; counts LATENCY cycles, then -> READ, beat=0.
//  READ: beat b drives cs=1,rwb=1,addr=4+b for ACCESS_CYCLES cycles; bus_rdata captured on the
//   final cycle of the beat into quotient[7:0],[15:8], remain[7:0],[15:8]. After beat 3 -> RESP.
//  RESP: rsp_valid=1, results held; rsp_valid&rsp_ready -> IDLE (req_ready=1 next cycle).
//   No new request accepted in the same cycle as the response handshake.
//  Request-to-rsp_valid latency: 8*ACCESS_CYCLES + LATENCY + 1 cycles (default 35).
//  denom=0: no special case; returns whatever the peripheral reads back.
//  Reset mid-operation: next cycle IDLE, cs=0, rsp_valid=0, partial results discarded.
//  rsp_ready asserted outside RESP: ignored. req_* changes outside IDLE: ignored.
// STRUCTURE
//  Package arith_bus_pkg: state enum {IDLE,WRITE,WAIT,READ,RESP}; localparams
//   REG_NUMER_LO..REG_DENOM_HI = 3'h0..3'h3, REG_QUOT_LO..REG_REM_HI = 3'h4..3'h7.
//  Flat single module: FSM, 2-bit beat counter, access-cycle counter
//   ($clog2(ACCESS_CYCLES) bits), wait counter ($clog2(LATENCY+1) bits). No sub-modules.
// TESTING (bench: behavioural responder with negedge writes, comb reads, LATENCY-cycle divide)
//  1000/7 -> rsp q=142 r=6 exactly 35 cycles after handshake; bus trace addr 0,1,2,3 then 4..7.
//  0xFFFF/0x0001 then 0x1234/0x0100 back-to-back -> q=0xFFFF r=0, then q=0x0012 r=0x0034.
//  rsp_ready low 10 cycles -> rsp_valid held, results stable, req_ready=0, bus_cs=0 throughout.
//  reset pulsed in WAIT -> next cycle IDLE, cs=0, rsp_valid=0; new 100/9 returns q=11 r=1.
//  LATENCY=0 build: 50/5 -> q=10 r=0 after 17 cycles, READ follows WRITE with no gap.
//  Random 500 requests incl. denom=0 -> every response matches responder model; no bus overlap.

Source files
------------

// File: rtl/arith_bus_pkg.sv
// Shared constants for the divide-peripheral bus master: FSM encodings, register map,
// and the operand-byte selector used while writing the request registers.
package arith_bus_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [2:0] REG_NUMER_LO = 3'h0;
  localparam logic [2:0] REG_NUMER_HI = 3'h1;
  localparam logic [2:0] REG_DENOM_LO = 3'h2;
  localparam logic [2:0] REG_DENOM_HI = 3'h3;
  localparam logic [2:0] REG_QUOT_LO  = 3'h4;
  localparam logic [2:0] REG_QUOT_HI  = 3'h5;
  localparam logic [2:0] REG_REM_LO   = 3'h6;
  localparam logic [2:0] REG_REM_HI   = 3'h7;

  // Byte of the latched request that belongs in a given operand register.
  function automatic logic [7:0] write_byte(input logic [15:0] numer,
                                            input logic [15:0] denom,
                                            input logic [2:0]  addr);
    case (addr)
      REG_NUMER_LO: write_byte = numer[7:0];
      REG_NUMER_HI: write_byte = numer[15:8];
      REG_DENOM_LO: write_byte = denom[7:0];
      REG_DENOM_HI: write_byte = denom[15:8];
      default:      write_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/arith_bus_master.sv
// Bus initiator for the memory-mapped divider: writes numer/denom bytes, waits the unit
// latency, reads quotient/remainder bytes and hands the result back over valid/ready.
module arith_bus_master
  import arith_bus_pkg::*;
#(
  parameter int OPER_W        = 16,
  parameter int LATENCY       = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPER_W-1:0] req_numer,
  input  logic [OPER_W-1:0] req_denom,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OPER_W-1:0] rsp_quotient,
  output logic [OPER_W-1:0] rsp_remain,
  output logic              busy,
  output logic              bus_cs,
  output logic              bus_rwb,
  output logic [2:0]        bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata
);

  localparam int ACC_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int WAIT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'(ACCESS_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  logic [2:0]        state;
  logic [1:0]        beat;
  logic [ACC_W-1:0]  acc_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [OPER_W-1:0] numer;
  logic [OPER_W-1:0] denom;

  logic [1:0] next_beat;
  logic       beat_done;
  logic [2:0] next_wr_addr;
  logic [2:0] next_rd_addr;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; rsp_valid and the result stay put until that edge, request inputs matter only then.
  assign req_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign next_beat    = beat + 2'd1;
  assign beat_done    = (acc_cnt == ACC_LAST);
  assign next_wr_addr = REG_NUMER_LO + {1'b0, next_beat};
  assign next_rd_addr = REG_QUOT_LO + {1'b0, next_beat};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      beat         <= '0;
      acc_cnt      <= '0;
      wait_cnt     <= '0;
      numer        <= '0;
      denom        <= '0;
      rsp_valid    <= 1'b0;
      rsp_quotient <= '0;
      rsp_remain   <= '0;
      bus_cs       <= 1'b0;
      bus_rwb      <= 1'b1;
      bus_addr     <= 3'd0;
      bus_wdata    <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            numer     <= req_numer;
            denom     <= req_denom;
            state     <= ST_WRITE;
            beat      <= '0;
            acc_cnt   <= '0;
            bus_cs    <= 1'b1;
            bus_rwb   <= 1'b0;
            bus_addr  <= REG_NUMER_LO;
            bus_wdata <= write_byte(req_numer, req_denom, REG_NUMER_LO);
          end
        end
        ST_WRITE: begin
          if (beat_done) begin
            acc_cnt <= '0;
            if (beat == 2'd3) begin
              beat    <= '0;
              bus_rwb <= 1'b1;
              if (LATENCY > 0) begin
                state    <= ST_WAIT;
                wait_cnt <= '0;
                bus_cs   <= 1'b0;
              end else begin
                // Zero-latency unit: go straight into the first read access.
                state    <= ST_READ;
                bus_addr <= REG_QUOT_LO;
              end
            end else begin
              beat      <= next_beat;
              bus_addr  <= next_wr_addr;
              bus_wdata <= write_byte(numer, denom, next_wr_addr);
            end
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= ST_READ;
            beat     <= '0;
            acc_cnt  <= '0;
            bus_cs   <= 1'b1;
            bus_rwb  <= 1'b1;
            bus_addr <= REG_QUOT_LO;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_READ: begin
          if (beat_done) begin
            // Sample on the last cycle of the access so the peripheral has settled.
            case (bus_addr)
              REG_QUOT_LO: rsp_quotient[7:0]  <= bus_rdata;
              REG_QUOT_HI: rsp_quotient[15:8] <= bus_rdata;
              REG_REM_LO:  rsp_remain[7:0]    <= bus_rdata;
              REG_REM_HI:  rsp_remain[15:8]   <= bus_rdata;
              default: ;
            endcase
            acc_cnt <= '0;
            if (beat == 2'd3) begin
              state     <= ST_RESP;
              beat      <= '0;
              bus_cs    <= 1'b0;
              rsp_valid <= 1'b1;
            end else begin
              beat     <= next_beat;
              bus_addr <= next_rd_addr;
            end
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus_cs    <= 1'b0;
          bus_rwb   <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_bus_master.sv
// Bench for arith_bus_master: behavioural divide peripheral on the bus, a cycle-level
// reference schedule derived from request timing, directed cases and random traffic.
module tb_arith_bus_master;

  localparam int LAT    = 18;
  localparam int AC     = 2;
  localparam int N_RAND = 500;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance (LATENCY = 18)
  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [15:0] req_numer, req_denom, rsp_quotient, rsp_remain;
  logic        bus_cs, bus_rwb;
  logic [2:0]  bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  arith_bus_master #(.OPER_W(16), .LATENCY(LAT), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_numer(req_numer), .req_denom(req_denom),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quotient(rsp_quotient), .rsp_remain(rsp_remain),
    .busy(busy), .bus_cs(bus_cs), .bus_rwb(bus_rwb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // zero-latency instance
  logic        req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0, busy_0;
  logic [15:0] req_numer_0, req_denom_0, rsp_quotient_0, rsp_remain_0;
  logic        bus_cs_0, bus_rwb_0;
  logic [2:0]  bus_addr_0;
  logic [7:0]  bus_wdata_0, bus_rdata_0;

  arith_bus_master #(.OPER_W(16), .LATENCY(0), .ACCESS_CYCLES(AC)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_0), .req_ready(req_ready_0), .req_numer(req_numer_0), .req_denom(req_denom_0),
    .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready_0), .rsp_quotient(rsp_quotient_0), .rsp_remain(rsp_remain_0),
    .busy(busy_0), .bus_cs(bus_cs_0), .bus_rwb(bus_rwb_0), .bus_addr(bus_addr_0),
    .bus_wdata(bus_wdata_0), .bus_rdata(bus_rdata_0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Divider behaviour: {quotient, remainder}; divide by zero gives all-ones and the numerator.
  function automatic logic [31:0] divide(input logic [15:0] n, input logic [15:0] d);
    if (d == 16'd0) return {16'hFFFF, n};
    return {n / d, n % d};
  endfunction

  function automatic logic [7:0] read_byte(input logic [31:0] res, input logic [2:0] addr);
    case (addr)
      3'd4:    return res[23:16];
      3'd5:    return res[31:24];
      3'd6:    return res[7:0];
      3'd7:    return res[15:8];
      default: return 8'hA5;
    endcase
  endfunction

  // Peripheral for the main instance: writes land on negedge, results only after LAT cycles.
  logic [7:0] regs [4];
  int cyc = 0;
  int last_wr = -1000;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus_cs && !bus_rwb) begin
      regs[bus_addr[1:0]] = bus_wdata;
      if (bus_addr == 3'd3) last_wr = cyc;
    end
  end
  always @* begin
    bus_rdata = 8'hA5;
    if (bus_cs && bus_rwb && (cyc > last_wr + LAT))
      bus_rdata = read_byte(divide({regs[1], regs[0]}, {regs[3], regs[2]}), bus_addr);
  end

  // Peripheral for the zero-latency instance.
  logic [7:0] regs_0 [4];
  always @(negedge clk) begin
    if (bus_cs_0 && !bus_rwb_0) regs_0[bus_addr_0[1:0]] = bus_wdata_0;
  end
  always @* begin
    bus_rdata_0 = 8'hA5;
    if (bus_cs_0 && bus_rwb_0)
      bus_rdata_0 = read_byte(divide({regs_0[1], regs_0[0]}, {regs_0[3], regs_0[2]}), bus_addr_0);
  end

  // Reference model: request acceptance and the cycle offset since that handshake.
  bit          m_idle = 1'b1;
  int          m_off = 0;
  logic [15:0] m_n, m_d;
  int          n_done = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_idle = 1'b1;
      m_off  = 0;
      exp_q.delete();
    end else if (m_idle) begin
      if (req_valid) begin
        m_idle = 1'b0;
        m_off  = 1;
        m_n    = req_numer;
        m_d    = req_denom;
        exp_q.push_back(divide(req_numer, req_denom));
      end
    end else if (m_off > 8 * AC + LAT && rsp_ready) begin
      m_idle = 1'b1;
      m_off  = 0;
      n_done++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      m_off++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  bit         chk_en = 1'b0;
  logic [2:0] trace[$];
  bit         prev_cs = 1'b0;
  logic [2:0] prev_addr = 3'd0;

  always @(negedge clk) begin
    bit          e_cs, e_rwb, e_resp;
    logic [2:0]  e_addr;
    logic [7:0]  e_wd;
    logic [31:0] ops;
    int          b;
    if (chk_en) begin
      e_resp = !m_idle && (m_off > 8 * AC + LAT);
      check("ctl", {req_ready, busy, rsp_valid}, {m_idle, !m_idle, e_resp});
      e_cs = 1'b0; e_rwb = 1'b1; e_addr = 3'd0; e_wd = 8'h00;
      ops  = {m_d, m_n};
      if (!m_idle && m_off <= 4 * AC) begin
        b = (m_off - 1) / AC;
        e_cs = 1'b1; e_rwb = 1'b0; e_addr = 3'(b); e_wd = ops[b*8 +: 8];
      end else if (!m_idle && m_off > 4 * AC + LAT && m_off <= 8 * AC + LAT) begin
        b = (m_off - 4 * AC - LAT - 1) / AC;
        e_cs = 1'b1; e_rwb = 1'b1; e_addr = 3'(4 + b);
      end
      if (e_cs && !e_rwb)
        check("bus_write", {bus_cs, bus_rwb, bus_addr, bus_wdata}, {e_cs, e_rwb, e_addr, e_wd});
      else if (e_cs)
        check("bus_read", {bus_cs, bus_rwb, bus_addr}, {e_cs, e_rwb, e_addr});
      else
        check("bus_idle", {bus_cs, bus_rwb}, 2'b01);
      if (e_resp) begin
        check("result_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("result", {rsp_quotient, rsp_remain}, exp_q[0]);
      end
      if (bus_cs && (!prev_cs || bus_addr != prev_addr)) trace.push_back(bus_addr);
      prev_cs   = bus_cs;
      prev_addr = bus_addr;
    end
  end

  // Driver: one request; holds rsp_ready low for 'hold' cycles, then accepts the response.
  int got_lat;
  task automatic run_req(input string name, input logic [15:0] n, input logic [15:0] d,
                         input int hold, input logic [15:0] eq, input logic [15:0] er);
    int t;
    req_valid = 1'b1; req_numer = n; req_denom = d; rsp_ready = 1'b0;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    check({name, "_accept"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; req_numer = 16'($urandom); req_denom = 16'($urandom);
    got_lat = 1;
    while (!rsp_valid && got_lat < 200) begin @(negedge clk); got_lat++; end
    check({name, "_rsp_seen"}, rsp_valid, 1);
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_ctl"}, {rsp_valid, req_ready, bus_cs}, 3'b100);
      check({name, "_hold_result"}, {rsp_quotient, rsp_remain}, {eq, er});
      @(negedge clk);
    end
    check({name, "_result"}, {rsp_quotient, rsp_remain}, {eq, er});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat0, cs_run, start, cycles;
    reset = 1'b1;
    req_valid = 1'b0; req_numer = '0; req_denom = '0; rsp_ready = 1'b0;
    req_valid_0 = 1'b0; req_numer_0 = '0; req_denom_0 = '0; rsp_ready_0 = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ctl", {req_ready, busy, rsp_valid}, 3'b100);
    check("reset_bus", {bus_cs, bus_rwb, bus_addr, bus_wdata}, {1'b0, 1'b1, 3'd0, 8'd0});
    check("reset_result", {rsp_quotient, rsp_remain}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1000 / 7 with latency and bus trace
    trace.delete();
    run_req("div_1000_7", 16'd1000, 16'd7, 0, 16'd142, 16'd6);
    check("lat_1000_7", got_lat, 35);
    check("trace_len", trace.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < trace.size()) check("trace_addr", trace[i], i);

    // back-to-back requests
    run_req("div_ffff_1", 16'hFFFF, 16'h0001, 0, 16'hFFFF, 16'h0000);
    run_req("div_1234_100", 16'h1234, 16'h0100, 0, 16'h0012, 16'h0034);

    // consumer stalls for 10 cycles
    run_req("stall", 16'd40000, 16'd123, 10, 16'd325, 16'd25);

    // reset while waiting on the unit
    req_valid = 1'b1; req_numer = 16'd5000; req_denom = 16'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_ctl", {req_ready, busy, rsp_valid, bus_cs}, 4'b1000);
    reset = 1'b0;
    @(negedge clk);
    run_req("div_100_9", 16'd100, 16'd9, 0, 16'd11, 16'd1);

    // zero-latency build
    check("l0_ready", req_ready_0, 1);
    req_valid_0 = 1'b1; req_numer_0 = 16'd50; req_denom_0 = 16'd5;
    @(negedge clk);
    req_valid_0 = 1'b0;
    lat0 = 1; cs_run = 0;
    while (!rsp_valid_0 && lat0 < 100) begin
      if (bus_cs_0) cs_run++;
      @(negedge clk);
      lat0++;
    end
    check("l0_latency", lat0, 17);
    check("l0_cs_no_gap", cs_run, 16);
    check("l0_result", {rsp_quotient_0, rsp_remain_0}, {16'd10, 16'd0});
    rsp_ready_0 = 1'b1;
    @(negedge clk);
    rsp_ready_0 = 1'b0;
    check("l0_back_idle", {req_ready_0, rsp_valid_0}, 2'b10);

    // random traffic
    start = n_done;
    cycles = 0;
    while (n_done - start < N_RAND && cycles < 60000) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_numer = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       req_denom = 16'd0;
        1:       req_denom = 16'($urandom_range(1, 15));
        2:       req_denom = 16'hFFFF;
        default: req_denom = 16'($urandom);
      endcase
      rsp_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      cycles++;
    end
    check("random_done", n_done - start, N_RAND);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
